board_pixel_scan: RTL and testbench

Pixel-scan source for the 2048 tile color lookup. It generates 640x480@60 VGA timing from the 50 MHz system clock and walks a 4x4 board snapshot. For every pixel it emits the 4-bit tile code (0 = empty, 1..11 = 2..2048) plus the in-tile flag that the color stage consumes. Syncs and tile outputs leave through the same pipeline register, so they stay aligned.

---
 rtl/vga_board_pkg.sv | 38 +++
 rtl/board_pixel_scan_if.sv | 24 ++
 rtl/vga_timing.sv | 85 ++++++++
 rtl/board_pixel_scan.sv | 170 +++++++++++++++++
 tb/tb_board_pixel_scan.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_board_pkg
//  Description : Shared VGA timing defaults, board geometry defaults, tile
//                types and the board cell lookup helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_board_pkg;

    // 640x480@60 timing in 25 MHz pixel ticks
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Board placement on screen
    localparam int BOARD_X0_DEF = 120;
    localparam int BOARD_Y0_DEF = 40;
    localparam int TILE_DEF     = 100;
    localparam int GAP_DEF      = 5;

    // Counter width covers totals up to 1023
    localparam int CNT_W = 10;

    typedef logic [3:0]  tile_code_t;
    typedef logic [63:0] board_t;

    // Cell k = row*4+col sits at b[4k+3:4k]; {row,col,2'b00} is 4k
    function automatic tile_code_t cell_code(board_t b, logic [1:0] row, logic [1:0] col);
        return b[{row, col, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_pixel_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_pixel_scan_if
//  Description : Board snapshot input and per-pixel video/tile outputs of
//                the pixel-scan source.
//  Revision    : 1.0 - initial release
// ============================================================================
interface board_pixel_scan_if;
    logic [63:0] board_in;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [3:0]  state;
    logic        inpos;
    logic        frame_start;

    // Scan block side
    modport slave  (input  board_in,
                    output hsync, vsync, video_on, state, inpos, frame_start);
    // Board owner / color stage side
    modport master (output board_in,
                    input  hsync, vsync, video_on, state, inpos, frame_start);
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Pixel-enable divider, horizontal/vertical counters and the
//                raw (unregistered) sync and active-area decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_board_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             h_last,
    output logic             v_last,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             video_on
);

    localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] c_hs_start = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_vs_start = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic             pix_en_d,  pix_en_q;
    logic [CNT_W-1:0] hcount_d,  hcount_q;
    logic [CNT_W-1:0] vcount_d,  vcount_q;

    assign h_last = (hcount_q == c_h_last);
    assign v_last = (vcount_q == c_v_last);

    // Next-state: pixel enable toggles every clk, counters step on pixel ticks
    always_comb begin
        pix_en_d = ~pix_en_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + c_one;
            end else begin
                hcount_d = hcount_q + c_one;
            end
        end
    end

    // Counter and divider state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pix_en   = pix_en_q;
    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign hsync_n  = ~((hcount_q >= c_hs_start) && (hcount_q <= c_hs_end));
    assign vsync_n  = ~((vcount_q >= c_vs_start) && (vcount_q <= c_vs_end));
    assign video_on = (hcount_q < c_h_act) && (vcount_q < c_v_act);

endmodule
`default_nettype wire

// File: rtl/board_pixel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : board_pixel_scan
//  Description : VGA pixel-scan source for the 4x4 tile board. Tracks the
//                tile under the beam without arithmetic division, snapshots
//                the board once per frame in blanking and registers syncs and
//                tile outputs together so they stay aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_pixel_scan
    import vga_board_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int BOARD_X0 = BOARD_X0_DEF,
    parameter int BOARD_Y0 = BOARD_Y0_DEF,
    parameter int TILE     = TILE_DEF,
    parameter int GAP      = GAP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    board_pixel_scan_if.slave bus
);

    localparam int               c_off_w   = $clog2(TILE);
    localparam logic [CNT_W-1:0] c_x_first = CNT_W'(BOARD_X0);
    localparam logic [CNT_W-1:0] c_x_last  = CNT_W'(BOARD_X0 + 4 * TILE - 1);
    localparam logic [CNT_W-1:0] c_y_first = CNT_W'(BOARD_Y0);
    localparam logic [CNT_W-1:0] c_y_last  = CNT_W'(BOARD_Y0 + 4 * TILE - 1);
    localparam logic [CNT_W-1:0] c_v_act   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [c_off_w-1:0] c_off_last = c_off_w'(TILE - 1);
    localparam logic [c_off_w-1:0] c_off_one  = c_off_w'(1);
    localparam logic [c_off_w-1:0] c_in_lo    = c_off_w'(GAP);
    localparam logic [c_off_w-1:0] c_in_hi    = c_off_w'(TILE - GAP - 1);

    logic             w_pix_en, w_h_last, w_v_last;
    logic             w_hsync_n, w_vsync_n, w_video_on;
    logic [CNT_W-1:0] w_hcount, w_vcount, w_h_next, w_v_next;
    logic             w_in_bx, w_in_by, w_in_board, w_inner;

    logic [c_off_w-1:0] hoff_d, hoff_q, voff_d, voff_q;
    logic [1:0]         col_d, col_q, row_d, row_q;
    board_t             board_d, board_q;
    logic               hsync_d, hsync_q, vsync_d, vsync_q;
    logic               video_on_d, video_on_q, inpos_d, inpos_q;
    logic               frame_start_d, frame_start_q;
    tile_code_t         state_d, state_q;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (w_pix_en),
        .hcount   (w_hcount),
        .vcount   (w_vcount),
        .h_last   (w_h_last),
        .v_last   (w_v_last),
        .hsync_n  (w_hsync_n),
        .vsync_n  (w_vsync_n),
        .video_on (w_video_on)
    );

    // Counter values after the coming tick; tile offsets restart when these hit the board edge
    assign w_h_next   = w_h_last ? '0 : w_hcount + c_one;
    assign w_v_next   = w_v_last ? '0 : w_vcount + c_one;
    assign w_in_bx    = (w_hcount >= c_x_first) && (w_hcount <= c_x_last);
    assign w_in_by    = (w_vcount >= c_y_first) && (w_vcount <= c_y_last);
    assign w_in_board = w_video_on && w_in_bx && w_in_by;
    assign w_inner    = (hoff_q >= c_in_lo) && (hoff_q <= c_in_hi) &&
                        (voff_q >= c_in_lo) && (voff_q <= c_in_hi);

    // Tile tracking: offset within tile plus tile index, reloaded at the board edge
    always_comb begin
        hoff_d = hoff_q;
        col_d  = col_q;
        voff_d = voff_q;
        row_d  = row_q;
        if (w_pix_en) begin
            if (w_h_next == c_x_first) begin
                hoff_d = '0;
                col_d  = 2'd0;
            end else if (hoff_q == c_off_last) begin
                hoff_d = '0;
                col_d  = col_q + 2'd1;
            end else begin
                hoff_d = hoff_q + c_off_one;
            end
            if (w_h_last) begin
                if (w_v_next == c_y_first) begin
                    voff_d = '0;
                    row_d  = 2'd0;
                end else if (voff_q == c_off_last) begin
                    voff_d = '0;
                    row_d  = row_q + 2'd1;
                end else begin
                    voff_d = voff_q + c_off_one;
                end
            end
        end
    end

    // Snapshot on the first blank line and the aligned output register
    always_comb begin
        board_d       = board_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        state_d       = state_q;
        inpos_d       = inpos_q;
        // Cleared on the idle clk so the pulse lasts exactly one clk
        frame_start_d = w_pix_en && (w_hcount == '0) && (w_vcount == '0);
        if (w_pix_en) begin
            if ((w_hcount == '0) && (w_vcount == c_v_act)) begin
                board_d = bus.board_in;
            end
            hsync_d    = w_hsync_n;
            vsync_d    = w_vsync_n;
            video_on_d = w_video_on;
            state_d    = w_in_board ? cell_code(board_q, row_q, col_q) : 4'd0;
            inpos_d    = w_in_board && w_inner;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hoff_q        <= '0;
            col_q         <= 2'd0;
            voff_q        <= '0;
            row_q         <= 2'd0;
            board_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            state_q       <= 4'd0;
            inpos_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hoff_q        <= hoff_d;
            col_q         <= col_d;
            voff_q        <= voff_d;
            row_q         <= row_d;
            board_q       <= board_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            state_q       <= state_d;
            inpos_q       <= inpos_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_on_q;
    assign bus.state       = state_q;
    assign bus.inpos       = inpos_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_board_pixel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_pixel_scan
//  Description : Directed self-checking bench. A reduced-geometry instance
//                (56x37 totals, 40x30 active, board at (8,3), tile 6, gap 1)
//                covers frame-level behaviour; a default instance covers the
//                real 640x480 line timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_pixel_scan;

    localparam int HT = 56;
    localparam int FT = 56 * 37;
    localparam logic [63:0] BOARD_MOD12 = 64'h3210_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cur = -1;   // index of the pixel currently held in the output register

    always #10 clk = ~clk;

    board_pixel_scan_if sif ();
    board_pixel_scan_if dif ();

    board_pixel_scan #(
        .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_ACTIVE (30), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .BOARD_X0 (8), .BOARD_Y0 (3), .TILE (6), .GAP (1)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    board_pixel_scan u_def (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    task automatic tick();
        @(posedge clk);
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur = -1;
    endtask

    task automatic goto(int f, int h, int v);
        int tgt;
        tgt = f * FT + v * HT + h;
        while (cur < tgt) tick();
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        sif.board_in = BOARD_MOD12;
        dif.board_in = BOARD_MOD12;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        obs = {sif.hsync, sif.vsync, sif.video_on, sif.state, sif.inpos, sif.frame_start};
        checks++;
        if (obs !== 9'b1_1_0_0000_0_0) begin
            failures++;
            $display("FAIL reset_small: got %b want %b", obs, 9'b1_1_0_0000_0_0);
        end
        obs = {dif.hsync, dif.vsync, dif.video_on, dif.state, dif.inpos, dif.frame_start};
        checks++;
        if (obs !== 9'b1_1_0_0000_0_0) begin
            failures++;
            $display("FAIL reset_def: got %b want %b", obs, 9'b1_1_0_0000_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        cur = -1;
        tick();
        obs = {sif.hsync, sif.vsync, sif.video_on, sif.state, sif.inpos, sif.frame_start};
        checks++;
        if (obs !== 9'b1_1_1_0000_0_1) begin
            failures++;
            $display("FAIL first_tick_small: got %b want %b", obs, 9'b1_1_1_0000_0_1);
        end
        checks++;
        if (dif.frame_start !== 1'b1) begin
            failures++;
            $display("FAIL first_tick_def_fs: got %b want 1", dif.frame_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sif.frame_start !== 1'b0 || dif.frame_start !== 1'b0) begin
            failures++;
            $display("FAIL fs_one_clk: got %b/%b want 0/0", sif.frame_start, dif.frame_start);
        end
        @(posedge clk);
        #1;
        cur++;
        goto(0, 30, 1);
        checks++;
        if (sif.video_on !== 1'b1 || sif.hsync !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_active: video_on=%b hsync=%b want 1/1", sif.video_on, sif.hsync);
        end
        // Mid-line reset must act without waiting for a clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs = {sif.hsync, sif.vsync, sif.video_on, sif.state, sif.inpos, sif.frame_start};
        checks++;
        if (obs !== 9'b1_1_0_0000_0_0) begin
            failures++;
            $display("FAIL midline_reset_small: got %b want %b", obs, 9'b1_1_0_0000_0_0);
        end
        obs = {dif.hsync, dif.vsync, dif.video_on, dif.state, dif.inpos, dif.frame_start};
        checks++;
        if (obs !== 9'b1_1_0_0000_0_0) begin
            failures++;
            $display("FAIL midline_reset_def: got %b want %b", obs, 9'b1_1_0_0000_0_0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cur = -1;
        tick();
        checks++;
        if (sif.frame_start !== 1'b1 || dif.frame_start !== 1'b1) begin
            failures++;
            $display("FAIL fs_after_midline_reset: got %b/%b want 1/1", sif.frame_start, dif.frame_start);
        end
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, vid = 0, fs = 0;
        int first_hs = -1, first_vs = -1, last_vs = -1;
        do_reset();
        for (int i = 0; i < FT; i++) begin
            tick();
            if (sif.hsync === 1'b0) hs_low++;
            if (sif.vsync === 1'b0) begin
                vs_low++;
                last_vs = cur / HT;
                if (first_vs < 0) first_vs = cur / HT;
            end
            if (sif.video_on === 1'b1) vid++;
            if (sif.frame_start === 1'b1) fs++;
            if (cur < HT && sif.hsync === 1'b0 && first_hs < 0) first_hs = cur;
        end
        checks++;
        if (hs_low !== 222) begin failures++; $display("FAIL hsync_low_ticks: got %0d want 222", hs_low); end
        checks++;
        if (first_hs !== 44) begin failures++; $display("FAIL hsync_start: got %0d want 44", first_hs); end
        checks++;
        if (vs_low !== 112) begin failures++; $display("FAIL vsync_low_ticks: got %0d want 112", vs_low); end
        checks++;
        if (first_vs !== 32 || last_vs !== 33) begin
            failures++;
            $display("FAIL vsync_lines: got %0d..%0d want 32..33", first_vs, last_vs);
        end
        checks++;
        if (vid !== 1200) begin failures++; $display("FAIL video_on_ticks: got %0d want 1200", vid); end
        checks++;
        if (fs !== 1) begin failures++; $display("FAIL frame_start_count: got %0d want 1", fs); end
    endtask

    task automatic test_mapping();
        // Frame 1, snapshot of the mod-12 board taken at the end of frame 0
        int         mh [12] = '{10, 31, 32,  9, 15,  4, 14, 45, 25, 29, 16, 16};
        int         mv [12] = '{ 2,  3,  3,  4,  4,  5,  6, 10, 20, 24, 26, 27};
        logic [3:0] ms [12] = '{ 0,  3,  0,  0,  1,  0,  1,  0, 10,  3,  1,  0};
        logic       mi [12] = '{ 0,  0,  0,  1,  1,  0,  0,  0,  0,  1,  0,  0};
        logic       mo [12] = '{ 1,  1,  1,  1,  1,  1,  1,  0,  1,  1,  1,  1};
        logic       mhs[12] = '{ 1,  1,  1,  1,  1,  1,  1,  0,  1,  1,  1,  1};
        for (int i = 0; i < 12; i++) begin
            goto(1, mh[i], mv[i]);
            checks++;
            if (sif.state !== ms[i] || sif.inpos !== mi[i] ||
                sif.video_on !== mo[i] || sif.hsync !== mhs[i]) begin
                failures++;
                $display("FAIL map_(%0d,%0d): state=%0d inpos=%b video_on=%b hsync=%b want %0d %b %b %b",
                         mh[i], mv[i], sif.state, sif.inpos, sif.video_on, sif.hsync,
                         ms[i], mi[i], mo[i], mhs[i]);
            end
        end
    endtask

    task automatic test_snapshot();
        goto(2, 0, 15);
        sif.board_in = {16{4'hB}};
        goto(2, 15, 20);
        checks++;
        if (sif.state !== 4'd9 || sif.inpos !== 1'b0) begin
            failures++;
            $display("FAIL snap_old_(15,20): state=%0d inpos=%b want 9 0", sif.state, sif.inpos);
        end
        goto(2, 29, 24);
        checks++;
        if (sif.state !== 4'd3 || sif.inpos !== 1'b1) begin
            failures++;
            $display("FAIL snap_old_(29,24): state=%0d inpos=%b want 3 1", sif.state, sif.inpos);
        end
        goto(3, 15, 4);
        checks++;
        if (sif.state !== 4'd11 || sif.inpos !== 1'b1) begin
            failures++;
            $display("FAIL snap_new_(15,4): state=%0d inpos=%b want 11 1", sif.state, sif.inpos);
        end
        goto(3, 29, 24);
        checks++;
        if (sif.state !== 4'd11) begin
            failures++;
            $display("FAIL snap_new_(29,24): state=%0d want 11", sif.state);
        end
    endtask

    task automatic test_alignment();
        int found = -1;
        sif.board_in = 64'h5;
        goto(4, 7, 3);
        checks++;
        if (sif.state !== 4'd0) begin
            failures++;
            $display("FAIL align_before: state=%0d want 0", sif.state);
        end
        for (int i = 0; i < 12 && found < 0; i++) begin
            tick();
            if (sif.state === 4'd5) found = cur - 4 * FT;
        end
        checks++;
        if (found !== 3 * HT + 8) begin
            failures++;
            $display("FAIL align_first_pixel: got index %0d want %0d", found, 3 * HT + 8);
        end
        checks++;
        if (sif.hsync !== 1'b1 || sif.video_on !== 1'b1 || sif.inpos !== 1'b0) begin
            failures++;
            $display("FAIL align_companions: hsync=%b video_on=%b inpos=%b want 1 1 0",
                     sif.hsync, sif.video_on, sif.inpos);
        end
    endtask

    task automatic test_default_line();
        int  e_f1 = -1, e_r1 = -1, e_f2 = -1, e_v = -1;
        logic ph = 1'b1, pv = 1'b0;
        do_reset();
        for (int e = 1; e <= 3000; e++) begin
            @(posedge clk);
            #1;
            if (ph === 1'b1 && dif.hsync === 1'b0) begin
                if (e_f1 < 0) e_f1 = e;
                else if (e_f2 < 0) e_f2 = e;
            end
            if (ph === 1'b0 && dif.hsync === 1'b1 && e_r1 < 0) e_r1 = e;
            if (pv === 1'b1 && dif.video_on === 1'b0 && e_v < 0) e_v = e;
            ph = dif.hsync;
            pv = dif.video_on;
        end
        checks++;
        if (e_f1 !== 1314) begin failures++; $display("FAIL def_hsync_fall: got clk %0d want 1314", e_f1); end
        checks++;
        if (e_r1 - e_f1 !== 192) begin failures++; $display("FAIL def_hsync_width: got %0d clk want 192", e_r1 - e_f1); end
        checks++;
        if (e_f2 - e_f1 !== 1600) begin failures++; $display("FAIL def_line_period: got %0d clk want 1600", e_f2 - e_f1); end
        checks++;
        if (e_v !== 1282) begin failures++; $display("FAIL def_video_end: got clk %0d want 1282", e_v); end
    endtask

    initial begin
        test_reset();
        sif.board_in = BOARD_MOD12;
        test_timing();
        test_mapping();
        test_snapshot();
        test_alignment();
        test_default_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
